// File: rtl/cci_rd_arbiter.sv
// cci_rd_arbiter: round-robin sharing of the CCI-P c0 read channel with outstanding cap, tag routing and drain.
// Define CCI_RD_ARB_STATS_EN to add per-client grant_count and stall_cycles counters.
module cci_rd_arbiter #(
    parameter int NUM_CLIENTS     = 4,
    parameter int ADDR_WIDTH      = 42,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CLIENTS-1:0]                 client_rd_valid,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]      client_rd_addr,
    output logic [NUM_CLIENTS-1:0]                 client_rd_ready,
    output logic                                   c0_tx_valid,
    output logic [ADDR_WIDTH-1:0]                  c0_tx_addr,
    output logic [15:0]                            c0_tx_mdata,
    input  logic                                   c0_tx_almfull,
    input  logic                                   c0_rx_valid,
    input  logic [15:0]                            c0_rx_mdata,
    input  logic [511:0]                           c0_rx_data,
    output logic [NUM_CLIENTS-1:0]                 client_rsp_valid,
    output logic [511:0]                           client_rsp_data,
    input  logic                                   drain_req,
    output logic                                   drained,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   tag_error
`ifdef CCI_RD_ARB_STATS_EN
    ,
    output logic [NUM_CLIENTS*32-1:0]              grant_count,
    output logic [31:0]                            stall_cycles
`endif
);
    localparam int idWidth = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} stateType;

    stateType             state, stateNext;
    logic [idWidth-1:0]   ptr, gntId, idx, rxId;
    logic                 grantEn, found, anyGnt, badTag;

    always_comb begin
        grantEn = state == RUN && !c0_tx_almfull && 32'(outstanding) < MAX_OUTSTANDING;
        gntId = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            idx = idWidth'((int'(ptr) + k) % NUM_CLIENTS);
            if (!found && client_rd_valid[idx]) begin
                found = 1'b1;
                gntId = idx;
            end
        end
        anyGnt = grantEn && found;
        client_rd_ready = anyGnt ? NUM_CLIENTS'(1) << gntId : '0;
    end

    always_comb begin
        stateNext = state == RUN   ? (drain_req ? DRAIN : RUN)
                  : state == DRAIN ? (!drain_req ? RUN : (outstanding == '0 ? DRAINED : DRAIN))
                  : (drain_req ? DRAINED : RUN);
        rxId = c0_rx_mdata[idWidth-1:0];
        badTag = 32'(rxId) >= NUM_CLIENTS;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr              <= '0;
            drained          <= 1'b0;
            outstanding      <= '0;
            c0_tx_valid      <= 1'b0;
            c0_tx_addr       <= '0;
            c0_tx_mdata      <= '0;
            client_rsp_valid <= '0;
            client_rsp_data  <= '0;
            tag_error        <= 1'b0;
        end else begin
            drained     <= stateNext == DRAINED;
            c0_tx_valid <= anyGnt;
            if (anyGnt) begin
                ptr         <= 32'(gntId) == NUM_CLIENTS - 1 ? '0 : gntId + 1'b1;
                c0_tx_addr  <= client_rd_addr[int'(gntId)*ADDR_WIDTH +: ADDR_WIDTH];
                c0_tx_mdata <= 16'(gntId);
            end
            // A response with nothing counted in flight (e.g. after reset) must not wrap.
            if (anyGnt && !c0_rx_valid) outstanding <= outstanding + 1'b1;
            else if (!anyGnt && c0_rx_valid && outstanding != '0) outstanding <= outstanding - 1'b1;
            client_rsp_valid <= (c0_rx_valid && !badTag) ? NUM_CLIENTS'(1) << rxId : '0;
            if (c0_rx_valid) client_rsp_data <= c0_rx_data;
            tag_error <= tag_error | (c0_rx_valid & badTag);
        end
    end

`ifdef CCI_RD_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count  <= '0;
            stall_cycles <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++)
                if (client_rd_ready[i]) grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
            stall_cycles <= stall_cycles + 32'(|client_rd_valid && !anyGnt);
        end
    end
`endif
endmodule

// File: tb/tb_cci_rd_arbiter.sv
// tb_cci_rd_arbiter: vector table, directed corner sequences and randomized model check of cci_rd_arbiter.
module tb_cci_rd_arbiter;
    localparam int N = 4, AW = 42, MAXO = 4;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] v = '0;
    logic [N*AW-1:0] addr = '0;
    logic alm = 1'b0, rx = 1'b0, drain = 1'b0;
    logic [15:0] md = '0;
    logic [511:0] d = '0;

    logic [N-1:0] ready, rspValid;
    logic txValid, drainedO, tagErr;
    logic [AW-1:0] txAddr;
    logic [15:0] txMdata;
    logic [511:0] rspData;
    logic [2:0] outst;

    logic [2:0] ready3, rsp3;
    logic tx3Valid, drained3, tag3;
    logic [AW-1:0] tx3Addr;
    logic [15:0] tx3Mdata;
    logic [511:0] rsp3Data;
    logic [6:0] out3;

    cci_rd_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .client_rd_valid(v), .client_rd_addr(addr), .client_rd_ready(ready),
        .c0_tx_valid(txValid), .c0_tx_addr(txAddr), .c0_tx_mdata(txMdata), .c0_tx_almfull(alm),
        .c0_rx_valid(rx), .c0_rx_mdata(md), .c0_rx_data(d), .client_rsp_valid(rspValid),
        .client_rsp_data(rspData), .drain_req(drain), .drained(drainedO), .outstanding(outst),
        .tag_error(tagErr));

    cci_rd_arbiter #(.NUM_CLIENTS(3), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(64)) dut3 (
        .clk(clk), .rst(rst), .client_rd_valid(v[2:0]), .client_rd_addr(addr[3*AW-1:0]),
        .client_rd_ready(ready3), .c0_tx_valid(tx3Valid), .c0_tx_addr(tx3Addr), .c0_tx_mdata(tx3Mdata),
        .c0_tx_almfull(alm), .c0_rx_valid(rx), .c0_rx_mdata(md), .c0_rx_data(d),
        .client_rsp_valid(rsp3), .client_rsp_data(rsp3Data), .drain_req(drain), .drained(drained3),
        .outstanding(out3), .tag_error(tag3));

    int nChecks = 0, nErrors = 0;
    int mPtr, mOut, mMode;
    logic eTxValid, eDrained;
    logic [AW-1:0] eTxAddr;
    logic [15:0] eTxMdata;
    logic [N-1:0] eRsp;
    logic [511:0] eRspData;

    typedef struct {
        logic [N-1:0] v;
        logic a;
        logic r;
        logic [N-1:0] expReady;
        int expOut;
    } vecT;
    vecT tbl[15];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; v = '0; alm = 1'b0; rx = 1'b0; md = '0; d = '0; drain = 1'b0; addr = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_txvalid", txValid, 0);
        chk("rst_txaddr", txAddr, 0);
        chk("rst_txmdata", txMdata, 0);
        chk("rst_rspvalid", rspValid, 0);
        chk("rst_rspdata", rspData, 0);
        chk("rst_outstanding", outst, 0);
        chk("rst_drained", drainedO, 0);
        chk("rst3_outstanding", out3, 0);
        chk("rst3_tagerr", tag3, 0);
        rst = 1'b0;
        mPtr = 0; mOut = 0; mMode = 0;
        eTxValid = 0; eDrained = 0; eTxAddr = '0; eTxMdata = '0; eRsp = '0; eRspData = '0;
    endtask

    // One cycle: drive inputs, compare DUT with the model, then advance the model across the edge.
    task automatic step(input logic [N-1:0] vi, input logic ai, input logic ri, input logic [15:0] mi,
                        input logic di = 1'b0, input logic [511:0] dat = '0);
        int g, nm;
        @(negedge clk);
        v = vi; alm = ai; rx = ri; md = mi; drain = di; d = dat;
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'({$urandom(), $urandom()});
        #1;
        g = -1;
        if (mMode == 0 && !ai && mOut < MAXO)
            for (int k = 0; k < N; k++) begin
                int c = (mPtr + k) % N;
                if (g < 0 && vi[c]) g = c;
            end
        chk("ready", ready, g < 0 ? 0 : (1 << g));
        chk("tx_valid", txValid, eTxValid);
        chk("tx_addr", txAddr, eTxAddr);
        chk("tx_mdata", txMdata, eTxMdata);
        chk("rsp_valid", rspValid, eRsp);
        chk("rsp_data", rspData, eRspData);
        chk("drained", drainedO, eDrained);
        chk("outstanding", outst, mOut);
        chk("tag_error", tagErr, 0);
        eTxValid = g >= 0;
        if (g >= 0) begin
            eTxMdata = 16'(g);
            eTxAddr = addr[g*AW +: AW];
            mPtr = (g + 1) % N;
        end
        eRsp = ri ? N'(1) << mi[1:0] : '0;
        if (ri) eRspData = dat;
        nm = mMode == 0 ? (di ? 1 : 0) : mMode == 1 ? (!di ? 0 : (mOut == 0 ? 2 : 1)) : (di ? 2 : 0);
        mMode = nm;
        eDrained = nm == 2;
        if (g >= 0 && !ri) mOut++;
        else if (g < 0 && ri && mOut > 0) mOut--;
    endtask

    initial begin
        int grants;
        logic drn;
        logic [511:0] rd;
        tbl[0]  = '{4'hF, 1'b0, 1'b0, 4'h1, 1};
        tbl[1]  = '{4'hF, 1'b0, 1'b0, 4'h2, 2};
        tbl[2]  = '{4'hF, 1'b1, 1'b0, 4'h0, 2};
        tbl[3]  = '{4'h9, 1'b0, 1'b1, 4'h8, 2};
        tbl[4]  = '{4'h6, 1'b0, 1'b0, 4'h2, 3};
        tbl[5]  = '{4'h0, 1'b0, 1'b0, 4'h0, 3};
        tbl[6]  = '{4'h3, 1'b0, 1'b0, 4'h1, 4};
        tbl[7]  = '{4'hF, 1'b0, 1'b0, 4'h0, 4};
        tbl[8]  = '{4'hF, 1'b0, 1'b1, 4'h0, 3};
        tbl[9]  = '{4'hF, 1'b0, 1'b0, 4'h2, 4};
        tbl[10] = '{4'h4, 1'b0, 1'b1, 4'h0, 3};
        tbl[11] = '{4'h0, 1'b0, 1'b1, 4'h0, 2};
        tbl[12] = '{4'h0, 1'b0, 1'b1, 4'h0, 1};
        tbl[13] = '{4'h0, 1'b0, 1'b1, 4'h0, 0};
        tbl[14] = '{4'h0, 1'b0, 1'b1, 4'h0, 0};

        doReset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].a, tbl[i].r, 16'h0);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].expReady);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out", i), outst, tbl[i].expOut);
        end

        doReset();
        for (int i = 0; i < 8; i++) begin
            step(4'hF, 1'b0, i > 0, 16'h0);
            chk("rr_order", ready, 1 << (i % 4));
            if (i > 0) chk("rr_mdata", txMdata[1:0], (i - 1) % 4);
        end
        step(4'h0, 1'b0, 1'b0, 16'h0);
        chk("rr_mdata_last", txMdata[1:0], 3);

        doReset();
        grants = 0;
        for (int i = 0; i < 7; i++) begin
            step(4'h2, 1'b0, 1'b0, 16'h0);
            if (ready != 0) grants++;
        end
        chk("cap_grants", grants, 4);
        chk("cap_ready_low", ready, 0);
        grants = 0;
        step(4'h2, 1'b0, 1'b1, 16'h1);
        if (ready != 0) grants++;
        for (int i = 0; i < 4; i++) begin
            step(4'h2, 1'b0, 1'b0, 16'h0);
            if (ready != 0) grants++;
        end
        chk("cap_one_more", grants, 1);

        doReset();
        for (int i = 0; i < 3; i++) step(4'h1, 1'b0, 1'b0, 16'h0);
        step(4'h1, 1'b0, 1'b1, 16'h0);
        chk("same_cycle_grant", ready, 1);
        @(posedge clk);
        #1;
        chk("same_cycle_out", outst, 3);

        doReset();
        step(4'hF, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 1'b1, 1'b0, 16'h0);
            chk("almfull_ready", ready, 0);
            if (i > 0) chk("almfull_txvalid", txValid, 0);
        end
        step(4'hF, 1'b0, 1'b0, 16'h0);
        chk("almfull_resume", ready, 4'h2);

        doReset();
        step(4'h0, 1'b0, 1'b1, 16'h0002, 1'b0, {64{8'hA5}});
        step(4'h0, 1'b0, 1'b0, 16'h0);
        chk("rsp_strobe", rspValid, 4'b0100);
        chk("rsp_data_a5", rspData, {64{8'hA5}});
        chk("rsp3_strobe", rsp3, 3'b100);
        chk("rsp3_no_tagerr", tag3, 0);
        step(4'h0, 1'b0, 1'b1, 16'hFFF1, 1'b0, {16{32'h1234_5678}});
        step(4'h0, 1'b0, 1'b0, 16'h0);
        chk("rsp_upper_ignored", rspValid, 4'b0010);
        step(4'h0, 1'b0, 1'b1, 16'h0003);
        step(4'h0, 1'b0, 1'b0, 16'h0);
        chk("rsp3_bad_nostrobe", rsp3, 0);
        chk("rsp3_tagerr", tag3, 1);
        step(4'h0, 1'b0, 1'b0, 16'h0);
        chk("rsp3_tagerr_sticky", tag3, 1);

        doReset();
        for (int i = 0; i < 5; i++) step(4'h1, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        chk("drain_out5", out3, 5);
        step(4'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'hF, 1'b0, 1'b0, 16'h0, 1'b1);
            chk("drain_noready", ready3, 0);
            chk("drain_not_done", drained3, 0);
        end
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 1'b0, 1'b1, 16'h0, 1'b1);
            chk("drain_rsp_noready", ready3, 0);
            chk("drain_rsp_not_done", drained3, 0);
        end
        for (int i = 0; i < 4 && !drained3; i++) step(4'hF, 1'b0, 1'b0, 16'h0, 1'b1);
        chk("drain_done", drained3, 1);
        chk("drain_out0", out3, 0);
        step(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
        step(4'hF, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("drain_released", drained3, 0);
        chk("drain_resume", ready3, 3'b010);

        doReset();
        drn = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) drn = !drn;
            for (int j = 0; j < 16; j++) rd[j*32 +: 32] = $urandom();
            step(4'($urandom()), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 16'($urandom()), drn, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
